// File: rtl/seg7_decoder.sv
// seg7_decoder
// Reads active-low 7-segment patterns back into nibbles. Each pattern must
// stay unchanged for STABLE_CYCLES consecutive valid cycles before it is
// accepted. NUM_DIGITS accepted nibbles are assembled MS-first into one word,
// which is held on a valid/ready output until consumed.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   seg_in      active-low segment pattern, bit0 = a .. bit6 = g
//   seg_valid   seg_in is presented
//   seg_ready   pattern accepted this cycle (combinational)
//   word_out    assembled word, first accepted digit in the MS nibble
//   word_err    per-digit invalid-pattern flags, same ordering as word_out
//   word_valid  word_out/word_err complete and stable
//   word_ready  downstream consumes the word when high with word_valid
//
// state  | meaning
// IDLE   | waiting for a pattern; captures the first candidate cycle
// SETTLE | counting identical cycles of the candidate pattern
// OUT    | full word held for downstream; input back-pressured
module seg7_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  output logic [4*NUM_DIGITS-1:0] word_out,
  output logic [NUM_DIGITS-1:0]   word_err,
  output logic                    word_valid,
  input  logic                    word_ready
);

  localparam int WW = 4 * NUM_DIGITS;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int DW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  state_t          state_q;
  logic [6:0]      cand_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   digit_cnt_q;
  logic [WW-1:0]   word_q;
  logic [WW-1:0]   word_d;
  logic [NUM_DIGITS-1:0] err_q;
  logic [NUM_DIGITS-1:0] err_d;
  logic            word_valid_q;
  logic [3:0]      nibble;
  logic            nibble_err;
  logic            accept;

  // Decode the settled candidate; unknown patterns map to 0 with err set.
  always_comb begin
    nibble     = 4'h0;
    nibble_err = 1'b0;
    unique case (cand_q)
      7'h40: nibble = 4'h0;
      7'h79: nibble = 4'h1;
      7'h24: nibble = 4'h2;
      7'h30: nibble = 4'h3;
      7'h19: nibble = 4'h4;
      7'h12: nibble = 4'h5;
      7'h02: nibble = 4'h6;
      7'h78: nibble = 4'h7;
      7'h00: nibble = 4'h8;
      7'h10: nibble = 4'h9;
      7'h08: nibble = 4'hA;
      7'h03: nibble = 4'hB;
      7'h46: nibble = 4'hC;
      7'h21: nibble = 4'hD;
      7'h06: nibble = 4'hE;
      7'h0E: nibble = 4'hF;
      default: nibble_err = 1'b1;
    endcase
  end

  // The accepting cycle is the one where the live input still matches the
  // candidate and the count has reached its terminal value.
  assign accept    = (state_q == SETTLE) && seg_valid && (seg_in == cand_q) &&
                     (cnt_q == CNT_LAST);
  assign seg_ready = accept;

  // Shift-in written as shifts so NUM_DIGITS = 1 needs no special slice.
  assign word_d = (word_q << 4) | WW'(nibble);
  assign err_d  = (err_q << 1) | NUM_DIGITS'(nibble_err);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cand_q       <= 7'h7F;
      cnt_q        <= '0;
      digit_cnt_q  <= '0;
      word_q       <= '0;
      err_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (seg_valid) begin
            cand_q  <= seg_in;
            cnt_q   <= CW'(1);
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (!seg_valid) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (seg_in != cand_q) begin
            cand_q <= seg_in;
            cnt_q  <= CW'(1);
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            word_q      <= word_d;
            err_q       <= err_d;
            cnt_q       <= '0;
            digit_cnt_q <= digit_cnt_q + DW'(1);
            if (digit_cnt_q == DIG_LAST) begin
              state_q      <= OUT;
              word_valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        OUT: begin
          if (word_ready) begin
            state_q      <= IDLE;
            word_valid_q <= 1'b0;
            digit_cnt_q  <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          word_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign word_out   = word_q;
  assign word_err   = err_q;
  assign word_valid = word_valid_q;

endmodule
